frame_filler: RTL

Fills the visible region of a frame buffer in DRAM with a single 24-bit color. Sits directly downstream of the graphics command processor, which issues a FILL command on the valid/ready handshake below. It writes to the DRAM request controller's address and write-data FIFOs as 8-pixel bursts.

---
 rtl/frame_filler_if.sv | 53 +++++
 rtl/frame_filler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/frame_filler_if.sv
// frame_filler_if: groups the FILL command handshake and the DRAM request
// controller FIFO write ports that frame_filler drives.
//   slave  - the frame_filler side (accepts commands, pushes into FIFOs)
//   master - the command processor / FIFO side
`timescale 1ns/1ps

interface frame_filler_if;
    // Command processor handshake
    logic         valid;
    logic         ready;
    logic [23:0]  color;
    logic [31:0]  frame;

    // DRAM request controller FIFOs
    logic         af_full;
    logic         wdf_full;
    logic         af_wr_en;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic         wdf_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    modport slave (
        input  valid,
        input  color,
        input  frame,
        output ready,
        input  af_full,
        input  wdf_full,
        output af_wr_en,
        output af_cmd_din,
        output af_addr_din,
        output wdf_wr_en,
        output wdf_din,
        output wdf_mask_din
    );

    modport master (
        output valid,
        output color,
        output frame,
        input  ready,
        output af_full,
        output wdf_full,
        input  af_wr_en,
        input  af_cmd_din,
        input  af_addr_din,
        input  wdf_wr_en,
        input  wdf_din,
        input  wdf_mask_din
    );
endinterface

// File: rtl/frame_filler.sv
// frame_filler: fills the visible WIDTH x HEIGHT region of a frame buffer with
// one 24-bit color, emitting 8-pixel (32 B) bursts as one address push plus
// two 128-bit data pushes.
//
// Optional feature macro: FRAME_FILLER_CYCLES_EN
//   When defined, adds output fill_cycles[31:0], a saturating count of the
//   cycles spent outside IDLE during the most recent fill.
`timescale 1ns/1ps

module frame_filler #(
    parameter int WIDTH       = 800,
    parameter int HEIGHT      = 600,
    parameter int STRIDE_LOG2 = 12
) (
    input  logic          clk,
    input  logic          rst,
`ifdef FRAME_FILLER_CYCLES_EN
    output logic [31:0]   fill_cycles,
`endif
    frame_filler_if.slave bus
);

    // One extra bit on x so that "x + 8" never truncates, even for WIDTH=8.
    localparam int XW = $clog2(WIDTH) + 1;
    localparam int YW = $clog2(HEIGHT + 1);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 8);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_STEP = XW'(8);
    localparam logic [31:0]   STRIDE = 32'd1 << STRIDE_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PUSH1 = 2'd1,
        S_PUSH2 = 2'd2
    } state_t;

    state_t          state_reg;
    logic            ready_reg;
    logic            push1_reg;     // registered decode of S_PUSH1
    logic            push2_reg;     // registered decode of S_PUSH2
    logic [XW-1:0]   x_reg;
    logic [YW-1:0]   y_reg;
    logic [23:0]     color_reg;
    logic [31:0]     frame_reg;
    logic [31:0]     row_base_reg;  // frame + (y << STRIDE_LOG2), kept incrementally

    logic            push1_fire;
    logic            push2_fire;
    logic            last_burst;
    logic [31:0]     byte_addr;
    logic [127:0]    wdf_data;

    // The address push and first data push must go together, so PUSH1 needs
    // room in both FIFOs; PUSH2 only needs room for the second data beat.
    assign push1_fire = push1_reg & ~bus.af_full & ~bus.wdf_full;
    assign push2_fire = push2_reg & ~bus.wdf_full;
    assign last_burst = (x_reg == X_LAST) && (y_reg == Y_LAST);

    // Command FSM: accept in IDLE, then alternate PUSH1/PUSH2 per burst,
    // walking x across the row and y down the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            ready_reg    <= 1'b1;
            push1_reg    <= 1'b0;
            push2_reg    <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            color_reg    <= '0;
            frame_reg    <= '0;
            row_base_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.valid) begin
                        color_reg    <= bus.color;
                        frame_reg    <= bus.frame;
                        row_base_reg <= bus.frame;
                        x_reg        <= '0;
                        y_reg        <= '0;
                        state_reg    <= S_PUSH1;
                        ready_reg    <= 1'b0;
                        push1_reg    <= 1'b1;
                        push2_reg    <= 1'b0;
                    end
                end

                S_PUSH1: begin
                    if (push1_fire) begin
                        state_reg <= S_PUSH2;
                        push1_reg <= 1'b0;
                        push2_reg <= 1'b1;
                    end
                end

                S_PUSH2: begin
                    if (push2_fire) begin
                        push2_reg <= 1'b0;
                        if (last_burst) begin
                            state_reg <= S_IDLE;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= S_PUSH1;
                            push1_reg <= 1'b1;
                            if (x_reg == X_LAST) begin
                                x_reg        <= '0;
                                y_reg        <= y_reg + YW'(1);
                                row_base_reg <= row_base_reg + STRIDE;
                            end else begin
                                x_reg <= x_reg + X_STEP;
                            end
                        end
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b1;
                    push1_reg <= 1'b0;
                    push2_reg <= 1'b0;
                end
            endcase
        end
    end

    // Burst byte address; 32-bit wrap-around is intended.
    always_comb begin
        byte_addr = row_base_reg + (32'(x_reg) << 2);
    end

    // Only bits [27:5] reach the DRAM address; the rest are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{byte_addr[31:28], byte_addr[4:0], frame_reg[31:0]};

    // Four identical 32-bit pixels per data beat, alpha byte zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pixel
            assign wdf_data[gi*32 +: 32] = {8'h00, color_reg};
        end
    endgenerate

    assign bus.ready        = ready_reg;
    assign bus.af_wr_en     = push1_fire;
    assign bus.af_cmd_din   = 3'b000;
    assign bus.af_addr_din  = {6'd0, byte_addr[27:5], 2'b00};
    assign bus.wdf_wr_en    = push1_fire | push2_fire;
    assign bus.wdf_din      = wdf_data;
    assign bus.wdf_mask_din = 16'h0000;

`ifdef FRAME_FILLER_CYCLES_EN
    logic [31:0] cycles_reg;

    // Busy-cycle counter: cleared on accept, saturating count while not IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_reg <= '0;
        end else if (state_reg == S_IDLE) begin
            if (bus.valid) begin
                cycles_reg <= '0;
            end
        end else if (cycles_reg != 32'hFFFF_FFFF) begin
            cycles_reg <= cycles_reg + 32'd1;
        end
    end

    assign fill_cycles = cycles_reg;
`endif

endmodule
